// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared FSM state type, address-width helper and zero-register address for regfile_mp.
package regfile_mp_pkg;
  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;
  localparam int RF_ZERO_ADDR = 0;
  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/regfile_clear_ctrl.sv
// regfile_clear_ctrl: clear sequencer that walks every entry once after reset or a clear request.
module regfile_clear_ctrl import regfile_mp_pkg::*; #(
  parameter int NREGS = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_req,
  output logic                       ready,
  output logic                       clr_we,
  output logic [rf_aw(NREGS)-1:0]    clr_addr
);
  localparam int AW = rf_aw(NREGS);
  rf_state_t       r_state;
  logic [AW-1:0]   r_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RF_CLEAR;
      r_cnt   <= '0;
      ready   <= 1'b0;
    end else if (r_state == RF_IDLE) begin
      if (clear_req) begin
        r_state <= RF_CLEAR;
        r_cnt   <= '0;
        ready   <= 1'b0;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == AW'(NREGS - 1)) begin
        r_state <= RF_IDLE;
        ready   <= 1'b1;
      end
    end
  end
  assign clr_we   = r_state == RF_CLEAR;
  assign clr_addr = r_cnt;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with priority writes and a clear sequencer instead of an array reset.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp import regfile_mp_pkg::*; #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear_req,
  output logic                           ready,
  input  logic [NWR-1:0]                 we,
  input  logic [NWR*rf_aw(NREGS)-1:0]    waddr,
  input  logic [NWR*XLEN-1:0]            wdata,
  input  logic [NRD*rf_aw(NREGS)-1:0]    raddr,
  output logic [NRD*XLEN-1:0]            rdata
);
  localparam int AW = rf_aw(NREGS);
  logic [XLEN-1:0] r_mem [NREGS];
  logic            w_clr_we;
  logic [AW-1:0]   w_clr_addr;
  logic            w_wr_ok;
  regfile_clear_ctrl #(.NREGS(NREGS)) u_clr (
    .clk      (clk),
    .reset    (reset),
    .clear_req(clear_req),
    .ready    (ready),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );
  // a clear request drops any write presented in the same cycle
  assign w_wr_ok = ready & ~clear_req;
  // later ports overwrite earlier ones, so the highest enabled port wins
  always_ff @(posedge clk) begin
    if (w_clr_we)
      r_mem[w_clr_addr] <= '0;
    else if (w_wr_ok)
      for (int k = 0; k < NWR; k++)
        if (we[k] && !(ZERO_REG != 0 && waddr[k*AW +: AW] == AW'(RF_ZERO_ADDR)))
          r_mem[waddr[k*AW +: AW]] <= wdata[k*XLEN +: XLEN];
  end
  always_comb begin
    rdata = '0;
    for (int j = 0; j < NRD; j++)
      if (ready && !(ZERO_REG != 0 && raddr[j*AW +: AW] == AW'(RF_ZERO_ADDR))) begin
        rdata[j*XLEN +: XLEN] = r_mem[raddr[j*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
        for (int k = 0; k < NWR; k++)
          if (w_wr_ok && we[k] && waddr[k*AW +: AW] == raddr[j*AW +: AW])
            rdata[j*XLEN +: XLEN] = wdata[k*XLEN +: XLEN];
`endif
      end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed tests against an array model of the register file, checked every cycle.
module tb_regfile_mp;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;
  logic clk = 1'b0, reset, clear_req = 1'b0;
  logic [NWR-1:0]      we = '0;
  logic [NWR*AW-1:0]   waddr = '0;
  logic [NWR*XLEN-1:0] wdata = '0;
  logic [NRD*AW-1:0]   raddr = '0;
  logic                ready_z, ready_n;
  logic [NRD*XLEN-1:0] rdata_z, rdata_n;
  int checks = 0, failures = 0;
  int m_left = NREGS;
  logic [XLEN-1:0] mem_z [NREGS];
  logic [XLEN-1:0] mem_n [NREGS];

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) u_z (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_z),
    .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_z));
  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(0)) u_n (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_n),
    .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_n));

  // model: a clear counts down NREGS edges; contents are zero once it is over
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = NREGS;
      for (int i = 0; i < NREGS; i++) begin mem_z[i] = '0; mem_n[i] = '0; end
    end else if (m_left > 0)
      m_left = m_left - 1;
    else if (clear_req) begin
      m_left = NREGS;
      for (int i = 0; i < NREGS; i++) begin mem_z[i] = '0; mem_n[i] = '0; end
    end else
      for (int k = 0; k < NWR; k++)
        if (we[k]) begin
          mem_n[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
          if (waddr[k*AW +: AW] != 0) mem_z[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
        end
  end

  function automatic logic [XLEN-1:0] exp_rd(input bit zr, input int j);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    a = raddr[j*AW +: AW];
    if (m_left != 0 || (zr && a == 0)) return '0;
    v = zr ? mem_z[a] : mem_n[a];
`ifdef REGFILE_MP_BYPASS_EN
    for (int k = 0; k < NWR; k++)
      if (!clear_req && we[k] && waddr[k*AW +: AW] == a) v = wdata[k*XLEN +: XLEN];
`endif
    return v;
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ready_z", {31'b0, ready_z}, {31'b0, m_left == 0});
    chk("ready_n", {31'b0, ready_n}, {31'b0, m_left == 0});
    for (int j = 0; j < NRD; j++) begin
      chk("rdata_z", rdata_z[j*XLEN +: XLEN], exp_rd(1'b1, j));
      chk("rdata_n", rdata_n[j*XLEN +: XLEN], exp_rd(1'b0, j));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int p, input int a, input logic [XLEN-1:0] d);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = AW'(a);
    wdata[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_r(input int a0, input int a1);
    raddr = {AW'(a1), AW'(a0)};
  endtask

  task automatic wait_ready(input string name);
    int cyc;
    cyc = 0;
    while (!ready_z && cyc < 100) begin
      step();
      cyc++;
    end
    chk(name, cyc, 32);
  endtask

  initial begin
    reset = 1'b1;
    set_r(31, 7);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("ready_after_release", {31'b0, ready_z}, 32'd0);
    wait_ready("reset_latency");
    for (int a = 0; a < NREGS; a++) begin
      set_r(a, NREGS - 1 - a);
      #1 chk("post_reset_zero", rdata_z[XLEN-1:0], 32'd0);
    end
    // basic write/read
    set_w(0, 5, 32'hDEADBEEF);
    set_r(5, 5);
    step();
    we = '0;
    chk("basic_rd0", rdata_z[XLEN-1:0], 32'hDEADBEEF);
    chk("basic_rd1", rdata_z[2*XLEN-1:XLEN], 32'hDEADBEEF);
    // zero register
    set_w(0, 0, 32'h12345678);
    set_r(0, 5);
    step();
    we = '0;
    chk("zero_reg_z", rdata_z[XLEN-1:0], 32'd0);
    chk("zero_reg_n", rdata_n[XLEN-1:0], 32'h12345678);
    // conflict
    set_w(0, 7, 32'hAAAA);
    set_w(1, 7, 32'h5555);
    step();
    we = '0;
    set_r(7, 7);
    #1 chk("conflict_z", rdata_z[XLEN-1:0], 32'h5555);
    chk("conflict_n", rdata_n[2*XLEN-1:XLEN], 32'h5555);
    // same-cycle read of a register being written
    set_w(0, 9, 32'h1111);
    step();
    we = '0;
    set_w(0, 9, 32'hCAFE);
    set_r(9, 0);
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("bypass_same", rdata_z[XLEN-1:0], 32'hCAFE);
`else
    chk("bypass_same", rdata_z[XLEN-1:0], 32'h1111);
`endif
    step();
    we = '0;
    chk("bypass_next", rdata_z[XLEN-1:0], 32'hCAFE);
    // fill then clear, with a write to x3 in the request cycle
    for (int a = 1; a < NREGS; a++) begin
      set_w(0, a, 32'h100 + a);
      step();
    end
    we = '0;
    set_r(3, 31);
    #1 chk("fill_x3", rdata_z[XLEN-1:0], 32'h103);
    clear_req = 1'b1;
    set_w(0, 3, 32'h1);
    step();
    clear_req = 1'b0;
    we = '0;
    chk("clear_ready_low", {31'b0, ready_z}, 32'd0);
    begin
      int cyc;
      cyc = 0;
      while (!ready_z && cyc < 100) begin
        clear_req = (cyc == 5);
        if (cyc == 10) set_w(1, 4, 32'h77); else we = '0;
        step();
        cyc++;
      end
      clear_req = 1'b0;
      we = '0;
      chk("clear_latency", cyc, 32);
    end
    for (int a = 0; a < NREGS; a++) begin
      set_r(a, 3);
      #1 chk("post_clear_zero", rdata_n[XLEN-1:0], 32'd0);
    end
    chk("post_clear_x3", rdata_z[2*XLEN-1:XLEN], 32'd0);
    // reset in the middle of a clear restarts it
    set_w(0, 6, 32'h66);
    step();
    we = '0;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    #2 reset = 1'b0;
    wait_ready("reset_mid_clear");
    set_r(6, 0);
    #1 chk("x6_after_reset", rdata_z[XLEN-1:0], 32'd0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
